// File: rtl/rx_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module   : rx_seq_checker
//  Purpose  : Receive-side sequence checker. Parses a big-endian sequence
//             number (aux, AUX_BYTES wide) and a 16-bit segment index (seg)
//             from every received frame. Each frame is checked against the
//             expected (aux, seg) successor. The module counts checked,
//             matching, forward-gap, lost, stale and runt frames.
//  Ports    : clk, rst (sync, active-high)
//             seg_max  - segments per aux value (0 acts as 1)
//             rx_en    - frame valid, rx_data - frame byte
//             count/ok/ng/lostnum/stale (32b), runt (16b) - statistics
//             valid    - high in DONE, overrun - sticky FE-during-CALC
//             state    - IDLE=0, RUN=1, CALC=2, DONE=3
//  Options  : define RX_SEQ_CHECKER_STALE_EN to count duplicate or backward
//             frames in 'stale' and keep the expectation. Without it those
//             frames count as ng and resynchronise the expectation.
//  Revision : 1.0 - initial release
// ============================================================================
module rx_seq_checker #(
    parameter int AUX_BYTES  = 1,
    parameter int AUX_OFFSET = 0,
    parameter int SEG_OFFSET = AUX_OFFSET + AUX_BYTES,
    parameter int MAX_COUNT  = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seg_max,
    input  logic        rx_en,
    input  logic [7:0]  rx_data,
    output logic [31:0] count,
    output logic [31:0] ok,
    output logic [31:0] ng,
    output logic [31:0] lostnum,
    output logic [31:0] stale,
    output logic [15:0] runt,
    output logic        valid,
    output logic        overrun,
    output logic [1:0]  state
);

    localparam int AUX_W   = 8 * AUX_BYTES;
    localparam int PW      = AUX_W + 16;
    localparam int DW      = AUX_W + 18;
    localparam int AUX_END = AUX_OFFSET + AUX_BYTES;
    localparam int SEG_END = SEG_OFFSET + 2;
    localparam int NEED    = (AUX_END > SEG_END) ? AUX_END : SEG_END;
    localparam logic [31:0] MAXC  = 32'(MAX_COUNT);
    localparam bit          LIMIT = (MAX_COUNT != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic               armed_q, en_q, calc2_q, ad_msb_q;
    logic               valid_q, overrun_q;
    logic [31:0]        bcnt_q;
    logic [AUX_W-1:0]   aux_q, ea_q, ra_q;
    logic [15:0]        seg_q, es_q, rs_q, s_q;
    logic [PW-1:0]      prod_q;
    logic [31:0]        count_q, ok_q, ng_q, lostnum_q, stale_q;
    logic [15:0]        runt_q;

    // Successor of (a,s) with sm segments per aux value, packed {aux, seg}.
    function automatic logic [AUX_W+15:0] succ(input logic [AUX_W-1:0] a,
                                               input logic [15:0]      s,
                                               input logic [15:0]      sm);
        if (({1'b0, s} + 17'd1) < {1'b0, sm})
            return {a, s + 16'd1};
        else
            return {a + AUX_W'(1), 16'd0};
    endfunction

    logic               w_fe, w_complete, w_match, w_fwd;
    logic [15:0]        w_s;
    logic [31:0]        w_cnt_inc;
    logic [AUX_W+15:0]  w_succ_rx, w_succ_op;
    logic [AUX_W-1:0]   w_ad;
    logic [DW-1:0]      w_delta;
    logic [63:0]        w_lsum;

    always_comb begin
        w_fe       = en_q & ~rx_en;
        w_complete = (bcnt_q >= 32'(NEED));
        w_s        = (seg_max == 16'd0) ? 16'd1 : seg_max;
        w_match    = (aux_q == ea_q) && (seg_q == es_q);
        w_cnt_inc  = count_q + 32'd1;
        w_succ_rx  = succ(aux_q, seg_q, w_s);
        w_succ_op  = succ(ra_q, rs_q, s_q);
        w_ad       = ra_q - ea_q;
        // Two's-complement difference; the top bit is the sign.
        w_delta    = DW'(prod_q) + DW'(rs_q) - DW'(es_q);
        w_fwd      = ~ad_msb_q & ~w_delta[DW-1] & (w_delta != '0);
        w_lsum     = 64'(lostnum_q) + 64'(w_delta);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            armed_q   <= 1'b0;
            en_q      <= 1'b0;
            calc2_q   <= 1'b0;
            ad_msb_q  <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            bcnt_q    <= '0;
            aux_q     <= '0;
            ea_q      <= '0;
            ra_q      <= '0;
            seg_q     <= '0;
            es_q      <= '0;
            rs_q      <= '0;
            s_q       <= '0;
            prod_q    <= '0;
            count_q   <= '0;
            ok_q      <= '0;
            ng_q      <= '0;
            lostnum_q <= '0;
            stale_q   <= '0;
            runt_q    <= '0;
        end else begin
            // A frame already in progress at reset release is skipped:
            // counting is armed only once rx_en has been seen low.
            armed_q <= armed_q | ~rx_en;
            en_q    <= rx_en & armed_q;

            if (!rx_en) begin
                bcnt_q <= '0;
            end else if (armed_q) begin
                if (bcnt_q != '1)
                    bcnt_q <= bcnt_q + 32'd1;
                if (bcnt_q >= 32'(AUX_OFFSET) && bcnt_q < 32'(AUX_END))
                    aux_q <= AUX_W'({aux_q, rx_data});
                if (bcnt_q >= 32'(SEG_OFFSET) && bcnt_q < 32'(SEG_END))
                    seg_q <= {seg_q[7:0], rx_data};
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_fe) begin
                        if (!w_complete) begin
                            runt_q <= runt_q + 16'd1;
                        end else if (aux_q == '0 && seg_q == '0) begin
                            count_q      <= 32'd1;
                            ok_q         <= 32'd1;
                            {ea_q, es_q} <= w_succ_rx;
                            if (LIMIT && MAXC == 32'd1) begin
                                state_q <= ST_DONE;
                                valid_q <= 1'b1;
                            end else begin
                                state_q <= ST_RUN;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (w_fe) begin
                        if (!w_complete) begin
                            runt_q <= runt_q + 16'd1;
                        end else begin
                            count_q <= w_cnt_inc;
                            if (w_match) begin
                                ok_q         <= ok_q + 32'd1;
                                {ea_q, es_q} <= w_succ_rx;
                                if (LIMIT && w_cnt_inc == MAXC) begin
                                    state_q <= ST_DONE;
                                    valid_q <= 1'b1;
                                end
                            end else begin
                                // Operands are latched because capture of the
                                // next frame may overwrite aux_q/seg_q.
                                ra_q    <= aux_q;
                                rs_q    <= seg_q;
                                s_q     <= w_s;
                                calc2_q <= 1'b0;
                                state_q <= ST_CALC;
                            end
                        end
                    end
                end
                ST_CALC: begin
                    if (w_fe)
                        overrun_q <= 1'b1;
                    if (!calc2_q) begin
                        ad_msb_q <= w_ad[AUX_W-1];
                        prod_q   <= PW'(w_ad) * PW'(s_q);
                        calc2_q  <= 1'b1;
                    end else begin
                        if (w_fwd) begin
                            ng_q         <= ng_q + 32'd1;
                            lostnum_q    <= (w_lsum[63:32] != '0) ? 32'hFFFF_FFFF
                                                                  : w_lsum[31:0];
                            {ea_q, es_q} <= w_succ_op;
                        end else begin
`ifdef RX_SEQ_CHECKER_STALE_EN
                            stale_q      <= stale_q + 32'd1;
`else
                            ng_q         <= ng_q + 32'd1;
                            {ea_q, es_q} <= w_succ_op;
`endif
                        end
                        if (LIMIT && count_q == MAXC) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                default: ; // DONE: everything frozen until rst
            endcase
        end
    end

    assign count   = count_q;
    assign ok      = ok_q;
    assign ng      = ng_q;
    assign lostnum = lostnum_q;
    assign stale   = stale_q;
    assign runt    = runt_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;
    assign state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rx_seq_checker
//  Purpose  : Self-checking bench for rx_seq_checker. A table of frames with
//             expected statistics, followed by hand-written sequences for
//             latency, aux wrap, stale handling, overrun, MAX_COUNT and
//             reset-during-CALC.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rx_seq_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] seg_max;
    logic        rx_en;
    logic [7:0]  rx_data;

    logic [31:0] count, ok, ng, lostnum, stale;
    logic [15:0] runt;
    logic        valid, overrun;
    logic [1:0]  state;

    logic [31:0] l_count, l_ok, l_ng, l_lostnum, l_stale;
    logic [15:0] l_runt;
    logic        l_valid, l_overrun;
    logic [1:0]  l_state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rx_seq_checker #(.AUX_BYTES(1), .MAX_COUNT(0)) dut (
        .clk(clk), .rst(rst), .seg_max(seg_max), .rx_en(rx_en), .rx_data(rx_data),
        .count(count), .ok(ok), .ng(ng), .lostnum(lostnum), .stale(stale),
        .runt(runt), .valid(valid), .overrun(overrun), .state(state)
    );

    rx_seq_checker #(.AUX_BYTES(1), .MAX_COUNT(5)) dut_lim (
        .clk(clk), .rst(rst), .seg_max(seg_max), .rx_en(rx_en), .rx_data(rx_data),
        .count(l_count), .ok(l_ok), .ng(l_ng), .lostnum(l_lostnum), .stale(l_stale),
        .runt(l_runt), .valid(l_valid), .overrun(l_overrun), .state(l_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; rx_en = 1'b0; rx_data = 8'h00;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Drives one frame (aux, seg, fill bytes) then 'gap' idle cycles.
    // With gap=0 it returns at the FE cycle with rx_en already low.
    task automatic send(input logic [7:0] a, input logic [15:0] s, input int len, input int gap);
        for (int i = 0; i < len; i++) begin
            rx_en = 1'b1;
            if (i == 0)      rx_data = a;
            else if (i == 1) rx_data = s[15:8];
            else if (i == 2) rx_data = s[7:0];
            else             rx_data = 8'(i) ^ 8'hA5;
            @(negedge clk);
        end
        rx_en = 1'b0; rx_data = 8'h00;
        for (int i = 0; i < gap; i++) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " count"},   count,   0);
        chk({tag, " ok"},      ok,      0);
        chk({tag, " ng"},      ng,      0);
        chk({tag, " lostnum"}, lostnum, 0);
        chk({tag, " stale"},   stale,   0);
        chk({tag, " runt"},    32'(runt), 0);
        chk({tag, " valid"},   32'(valid), 0);
        chk({tag, " overrun"}, 32'(overrun), 0);
        chk({tag, " state"},   32'(state), 0);
    endtask

    typedef struct {
        logic [7:0]  aux;
        logic [15:0] seg;
        int          len;
        logic [31:0] e_cnt, e_ok, e_ng, e_lost, e_runt, e_st;
    } vec_t;

    vec_t tbl[17];

    task automatic setv(input int i, input logic [7:0] a, input logic [15:0] s, input int len,
                        input logic [31:0] c, input logic [31:0] o, input logic [31:0] g,
                        input logic [31:0] l, input logic [31:0] r, input logic [31:0] st);
        tbl[i].aux = a; tbl[i].seg = s; tbl[i].len = len;
        tbl[i].e_cnt = c; tbl[i].e_ok = o; tbl[i].e_ng = g;
        tbl[i].e_lost = l; tbl[i].e_runt = r; tbl[i].e_st = st;
    endtask

    initial begin
        seg_max = 16'd4;

        // Table: IDLE ignore, runt, sync, ordered run, forward gap, runt in RUN.
        setv(0, 8'd1, 16'd0, 8,  0, 0, 0, 0, 0, 0);
        setv(1, 8'd0, 16'd0, 2,  0, 0, 0, 0, 1, 0);
        setv(2, 8'd0, 16'd0, 64, 1, 1, 0, 0, 1, 1);
        for (int k = 1; k <= 11; k++)
            setv(2 + k, 8'(k / 4), 16'(k % 4), 64, 32'(k + 1), 32'(k + 1), 0, 0, 1, 1);
        setv(14, 8'd3, 16'd2, 8, 13, 12, 1, 2, 1, 1);   // expected (3,0): 2 lost
        setv(15, 8'd3, 16'd3, 8, 14, 13, 1, 2, 1, 1);
        setv(16, 8'd7, 16'd7, 1, 14, 13, 1, 2, 2, 1);   // runt while in RUN

        do_reset();
        chk_zero("reset");

        for (int i = 0; i < 17; i++) begin
            send(tbl[i].aux, tbl[i].seg, tbl[i].len, 12);
            chk($sformatf("v%0d count", i),   count,      tbl[i].e_cnt);
            chk($sformatf("v%0d ok", i),      ok,         tbl[i].e_ok);
            chk($sformatf("v%0d ng", i),      ng,         tbl[i].e_ng);
            chk($sformatf("v%0d lostnum", i), lostnum,    tbl[i].e_lost);
            chk($sformatf("v%0d runt", i),    32'(runt),  tbl[i].e_runt);
            chk($sformatf("v%0d state", i),   32'(state), tbl[i].e_st);
        end

        // Forward gap latency: (0,0),(0,1),(1,2) with seg_max=4 -> 4 lost.
        do_reset();
        send(8'd0, 16'd0, 3, 4);
        send(8'd0, 16'd1, 3, 4);
        send(8'd1, 16'd2, 3, 0);
        @(negedge clk);
        chk("gap FE+1 count", count, 3);
        chk("gap FE+1 state", 32'(state), 2);
        chk("gap FE+1 ng", ng, 0);
        @(negedge clk);
        chk("gap FE+2 state", 32'(state), 2);
        chk("gap FE+2 lostnum", lostnum, 0);
        @(negedge clk);
        chk("gap FE+3 ng", ng, 1);
        chk("gap FE+3 lostnum", lostnum, 4);
        chk("gap FE+3 state", 32'(state), 1);
        send(8'd1, 16'd3, 3, 4);
        chk("gap ok", ok, 3);
        chk("gap count", count, 4);

        // Aux wrap with seg_max=1, and MAX_COUNT=5 instance.
        do_reset();
        seg_max = 16'd1;
        for (int i = 0; i < 258; i++) begin
            send(8'(i), 16'd0, 3, 3);
            if (i == 3) begin
                chk("lim before valid", 32'(l_valid), 0);
                chk("lim before count", l_count, 4);
            end
            if (i == 4) begin
                chk("lim valid", 32'(l_valid), 1);
                chk("lim state", 32'(l_state), 3);
            end
        end
        chk("wrap ok", ok, 258);
        chk("wrap count", count, 258);
        chk("wrap ng", ng, 0);
        chk("lim frozen count", l_count, 5);
        chk("lim frozen ok", l_ok, 5);
        seg_max = 16'd0;                 // acts as 1
        send(8'd5, 16'd0, 3, 5);         // expected (2,0): 3 lost
        chk("jump lostnum", lostnum, 3);
        chk("jump ng", ng, 1);

        // Stale / backward frame: (0,1) after (0,2).
        do_reset();
        seg_max = 16'd4;
        send(8'd0, 16'd0, 3, 4);
        send(8'd0, 16'd1, 3, 4);
        send(8'd0, 16'd2, 3, 4);
        send(8'd0, 16'd1, 3, 5);
`ifdef RX_SEQ_CHECKER_STALE_EN
        chk("stale stale", stale, 1);
        chk("stale ng", ng, 0);
        send(8'd0, 16'd3, 3, 4);         // expectation kept at (0,3)
`else
        chk("stale stale", stale, 0);
        chk("stale ng", ng, 1);
        send(8'd0, 16'd2, 3, 4);         // resynchronised to (0,2)
`endif
        chk("stale lostnum", lostnum, 0);
        chk("stale ok after", ok, 4);
        chk("stale count", count, 5);

        // Overrun: a 1-byte frame ends during the second CALC cycle.
        send(8'd2, 16'd0, 3, 1);
        rx_en = 1'b1; rx_data = 8'h11;
        @(negedge clk);
        rx_en = 1'b0; rx_data = 8'h00;
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("ovr overrun", 32'(overrun), 1);
        chk("ovr runt", 32'(runt), 0);
        chk("ovr count", count, 6);
        chk("ovr state", 32'(state), 1);

        // Reset asserted while in CALC.
        send(8'd9, 16'd0, 3, 0);
        @(negedge clk);
        chk("rstcalc state", 32'(state), 2);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("rstcalc");
        chk("rstcalc lim state", 32'(l_state), 0);
        chk("rstcalc lim count", l_count, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
